// File: rtl/auc_pkg.sv
// Shared constants for the ECC ALU arbiter: opcodes, operand RAM map, arbiter states.
package auc_pkg;

  // opcode layout {carry, swap, op[1:0]}
  localparam logic [3:0] OP_FA   = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_INV  = 4'b0010;
  localparam logic [3:0] OP_EXP  = 4'b0011;
  localparam logic [3:0] OP_SWAP = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b1000;

  localparam int ZRRAM    = 18;
  localparam int ACCIDENT = 30;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/auc_arb_pick.sv
// Combinational winner select: first requester found scanning upward from ptr (wrapping).
// ptr tied to 0 gives fixed priority; AUC_ARB_RR_EN in the top drives a rotating ptr.
module auc_arb_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/auc_alu_arb.sv
// Arbiter/sequencer sharing one ECC ALU and operand RAM among NREQ micro-FSMs.
// Define AUC_ARB_RR_EN for round-robin pick; default is fixed priority (index 0 highest).
module auc_alu_arb
  import auc_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WID   = 256,
  parameter int AWID  = 5,
  parameter int OPWID = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic [NREQ*OPWID-1:0] req_opcode,
  input  logic [NREQ-1:0]       req_auen,
  input  logic [NREQ-1:0]       req_carry,
  input  logic [NREQ-1:0]       req_swapop,
  input  logic [NREQ-1:0]       req_swapvl,
  input  logic [NREQ*AWID-1:0]  req_ra,
  input  logic [NREQ*AWID-1:0]  req_wa,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*WID-1:0]   req_wd,
  output logic [NREQ-1:0]       req_auvld,
  output logic [OPWID-1:0]      alu_opcode,
  output logic                  alu_auen,
  output logic                  alu_carry,
  output logic                  alu_swapop,
  output logic                  alu_swapvl,
  input  logic                  alu_auvld,
  output logic [AWID-1:0]       ram_ra,
  output logic [AWID-1:0]       ram_wa,
  output logic                  ram_we,
  output logic [WID-1:0]        ram_wd,
  output logic                  arb_busy,
  output logic                  arb_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state, state_n;
  logic [NREQ-1:0] gnt_n, pick_gnt;
  logic [IW-1:0]   ptr;
  logic            busy_n, err_n, own_req, fwd_auen, fwd_we;

  auc_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  // Owner mux; with no grant the RAM addresses park on harmless locations.
  always_comb begin
    alu_opcode = '0;
    alu_carry  = 1'b0;
    alu_swapop = 1'b0;
    alu_swapvl = 1'b0;
    ram_ra     = AWID'(ZRRAM);
    ram_wa     = AWID'(ACCIDENT);
    ram_wd     = '0;
    fwd_auen   = 1'b0;
    fwd_we     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_opcode = req_opcode[i*OPWID +: OPWID];
        alu_carry  = req_carry[i];
        alu_swapop = req_swapop[i];
        alu_swapvl = req_swapvl[i];
        ram_ra     = req_ra[i*AWID +: AWID];
        ram_wa     = req_wa[i*AWID +: AWID];
        ram_wd     = req_wd[i*WID +: WID];
        fwd_auen   = req_auen[i];
        fwd_we     = req_we[i];
      end
    end
    // a draining owner may not start new work
    alu_auen = fwd_auen & (state == ARB_GRANT);
    ram_we   = fwd_we   & (state == ARB_GRANT);
  end

  assign own_req   = |(req & gnt);
  assign req_auvld = (alu_auvld && arb_busy) ? gnt : '0;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    case (state)
      ARB_IDLE: if (|req) begin
        state_n = ARB_GRANT;
        gnt_n   = pick_gnt;
      end
      ARB_GRANT: if (!own_req) begin
        if (arb_busy) begin
          state_n = ARB_DRAIN;
        end else begin
          state_n = ARB_IDLE;
          gnt_n   = '0;
        end
      end
      ARB_DRAIN: if (alu_auvld) begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
    busy_n = alu_auen ? 1'b1 : (alu_auvld ? 1'b0 : arb_busy);
    err_n  = arb_err | (|((req_auen | req_we) & ~gnt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      arb_busy <= 1'b0;
      arb_err  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      arb_busy <= busy_n;
      arb_err  <= err_n;
    end
  end

`ifdef AUC_ARB_RR_EN
  logic [IW-1:0] ptr_n;

  // next search starts just past the newly granted owner
  always_comb begin
    ptr_n = ptr;
    for (int i = 0; i < NREQ; i++)
      if (pick_gnt[i]) ptr_n = (i == NREQ-1) ? '0 : IW'(i + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ptr <= '0;
    else if (state == ARB_IDLE && |req) ptr <= ptr_n;
  end
`else
  assign ptr = '0;
`endif

endmodule
